// File: rtl/sort_result_streamer.sv
// Streams a sorted DEPTH x DW memory out over valid/ready, one element per
// FETCH/CAPT/SEND pass, and flags any break in monotonic order (sticky).
module sort_result_streamer #(
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int DW     = 8,
    parameter bit ASCEND = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          order_err
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] CAPT  = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [2:0]    state;
    logic [AW-1:0] idx;
    logic [DW-1:0] prev;
    logic          at_last;
    logic          viol;

    assign at_last = (idx == LAST_IDX);
    // Unsigned compare against the previously captured element.
    assign viol    = ASCEND ? (rd_data < prev) : (rd_data > prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            prev      <= '0;
            out_data  <= '0;
            order_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        order_err <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: state <= CAPT;
                CAPT: begin
                    out_data <= rd_data;
                    // Element 0 has no predecessor, so it is never flagged.
                    if (idx != '0 && viol) order_err <= 1'b1;
                    prev  <= rd_data;
                    state <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        if (at_last) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_en     = (state == FETCH);
    assign rd_addr   = rd_en ? idx : '0;
    assign out_valid = (state == SEND);
    assign out_last  = out_valid && at_last;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_sort_result_streamer.sv
// Directed + randomized bench for sort_result_streamer with a memory model
// and an element-level reference (expected stream, cumulative order flag).
module tb_sort_result_streamer;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, busy, done, order_err;

    logic [DW-1:0] mem [DEPTH];
    int checks   = 0;
    int failures = 0;

    sort_result_streamer #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .ASCEND(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
        .order_err(order_err)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous-read memory.
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_order_err"}, order_err, 0);
    endtask

    // Runs one stream. stall_elem/stall_len drop out_ready while that element
    // is offered; restart_elem pulses start during that element; abort_elem
    // asserts reset while that element is offered.
    task automatic do_run(input string tag, input int stall_elem, input int stall_len,
                          input int restart_elem, input int abort_elem);
        logic [DW-1:0] expv [DEPTH];
        bit            exp_err [DEPTH];
        bit            err;
        int n, cyc, stalled, dones, done_cyc, first_valid;
        err = 0;
        for (int k = 0; k < DEPTH; k++) begin
            expv[k] = mem[k];
            if (k > 0 && mem[k] < mem[k-1]) err = 1;
            exp_err[k] = err;
        end
        n = 0; stalled = 0; dones = 0; done_cyc = -1; first_valid = -1;
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 1000) begin
            if (done_cyc >= 0) begin
                chk({tag, "_idle_after_done"}, busy, 0);
                chk({tag, "_done_single"}, done, 0);
                break;
            end
            if (abort_elem == n && out_valid) begin
                rst = 1'b0;
                #1;
                chk_all_zero({tag, "_async_rst"});
                repeat (3) begin
                    @(negedge clk);
                    chk({tag, "_rst_no_done"}, done, 0);
                end
                rst = 1'b1;
                @(negedge clk);
                return;
            end
            if (!out_ready) begin
                chk({tag, "_stall_rd_en"}, rd_en, 0);
                chk({tag, "_stall_valid"}, out_valid, 1);
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (rd_en) chk({tag, "_rd_addr"}, rd_addr, n);
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                chk({tag, "_data"}, out_data, expv[n]);
                chk({tag, "_last"}, out_last, (n == DEPTH-1));
                chk({tag, "_order_err"}, order_err, exp_err[n]);
            end
            start = (out_valid && n == restart_elem);
            if (out_valid && n == stall_elem && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) n++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_n_xfers"}, n, DEPTH);
        chk({tag, "_first_valid_cyc"}, first_valid, 3);
        chk({tag, "_done_cyc"}, done_cyc, 3*DEPTH + 1 + stall_len);
        chk({tag, "_final_order_err"}, order_err, err);
    endtask

    task automatic fill_sorted_random();
        int v;
        v = $urandom_range(0, 20);
        for (int k = 0; k < DEPTH; k++) begin
            v += $urandom_range(0, 7);
            mem[k] = DW'(v);
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset_idle");

        // Ascending 0..31.
        for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k);
        do_run("asc", -1, 0, -1, -1);

        // Descending data: flag set at element 1, sticky after done.
        for (int k = 0; k < DEPTH; k++) mem[k] = DW'(DEPTH-1-k);
        do_run("desc", -1, 0, -1, -1);
        repeat (3) @(negedge clk);
        chk("desc_sticky", order_err, 1);
        fill_sorted_random();
        do_run("clear_err", -1, 0, -1, -1);

        // Backpressure: element 7 held for 5 cycles.
        for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k);
        do_run("stall", 7, 5, -1, -1);

        // All equal entries are legal.
        for (int k = 0; k < DEPTH; k++) mem[k] = 8'hAA;
        do_run("equal", -1, 0, -1, -1);

        // Reset mid-run at element 10, then a fresh run from address 0.
        fill_sorted_random();
        do_run("abort", -1, 0, -1, 10);
        chk_all_zero("after_abort");
        do_run("after_abort_run", -1, 0, -1, -1);

        // Start while busy is ignored.
        do_run("restart_ignored", -1, 0, 4, -1);

        // Randomized data and backpressure.
        for (int r = 0; r < 4; r++) begin
            if (r[0]) fill_sorted_random();
            else for (int k = 0; k < DEPTH; k++) mem[k] = DW'($urandom);
            do_run("rand", $urandom_range(0, DEPTH-1), $urandom_range(0, 6), -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
